// File: rtl/ub_pkg.sv
// Shared sizing helpers and types for unified-buffer delay structures.
// Pure declarations: no logic, no latency, no flow control.
package ub_pkg;

   localparam int DELAY_W = 16;

   typedef logic [DELAY_W-1:0] delay_t;

   // $clog2 that never returns 0, so 1-entry structures still get a 1-bit index
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ub_ring_mem.sv
// WIDTH x DEPTH ring storage: one synchronous write port, NTAPS combinational read ports.
// Write visible on reads the cycle after the edge; no reset and no backpressure.
module ub_ring_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 66,
   parameter int NTAPS = 4,
   parameter int AW    = 7
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic [NTAPS*AW-1:0]    raddr,
   output logic [NTAPS*WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   for (genvar t = 0; t < NTAPS; t++) begin : g_rd
      assign rdata[t*WIDTH +: WIDTH] = mem[raddr[t*AW +: AW]];
   end

endmodule

// File: rtl/ub_multitap_delay_line.sv
// Shared-ring multi-tap delay line: tap t shows the word accepted D_t advances ago (D=0 bypasses).
// Outputs are combinational from registered state; in_en=0 stalls everything, flush clears fill state.
module ub_multitap_delay_line
   import ub_pkg::*;
#(
   parameter int                         WIDTH      = 16,
   parameter int                         NTAPS      = 4,
   parameter logic [NTAPS*DELAY_W-1:0]   TAP_DELAYS = {16'd66, 16'd65, 16'd1, 16'd2},
   parameter int                         MAX_DELAY  = 66,
   parameter bit                         STALL_EN   = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic                                 in_en,
   input  logic [WIDTH-1:0]                     in_data,
   output logic [NTAPS*WIDTH-1:0]               out_data,
   output logic [NTAPS-1:0]                     out_valid,
   output logic [clog2_min1(MAX_DELAY+1)-1:0]   fill_count
);

   localparam int DEPTH = (MAX_DELAY > 1) ? MAX_DELAY : 1;
   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int CNT_W = clog2_min1(MAX_DELAY + 1);

   localparam logic [PTR_W-1:0] WP_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DELAY);

   if (NTAPS < 1) begin : g_bad_ntaps
      $fatal(1, "ub_multitap_delay_line: NTAPS must be >= 1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "ub_multitap_delay_line: WIDTH must be >= 1");
   end

   logic                     adv;
   logic                     wr;
   logic [PTR_W-1:0]         wp;
   logic [NTAPS*PTR_W-1:0]   raddr;
   logic [NTAPS*WIDTH-1:0]   rdata;

   assign adv = STALL_EN ? in_en : 1'b1;
   assign wr  = adv & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp         <= '0;
         fill_count <= '0;
      end else if (flush) begin
         wp         <= '0;
         fill_count <= '0;
      end else if (adv) begin
         wp <= (wp == WP_LAST) ? '0 : wp + 1'b1;
         if (fill_count != CNT_MAX) begin
            fill_count <= fill_count + 1'b1;
         end
      end
   end

   ub_ring_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NTAPS (NTAPS),
      .AW    (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr),
      .waddr (wp),
      .wdata (in_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   // TAP_DELAYS is written MSB-first: the leftmost literal entry belongs to tap 0
   for (genvar t = 0; t < NTAPS; t++) begin : g_tap
      localparam int D = int'(TAP_DELAYS[(NTAPS-1-t)*DELAY_W +: DELAY_W]);

      if (D > MAX_DELAY) begin : g_bad_delay
         $fatal(1, "ub_multitap_delay_line: tap delay exceeds MAX_DELAY");
      end

      logic [PTR_W-1:0] ra;
      logic [WIDTH-1:0] tap_word;
      logic             tap_vld;

      always_comb begin
         int a;
         a = int'(wp) - D;
         if (a < 0) begin
            a = a + DEPTH;
         end
         ra = a[PTR_W-1:0];
      end

      assign raddr[t*PTR_W +: PTR_W] = ra;
      assign tap_word = (D == 0) ? in_data : rdata[t*WIDTH +: WIDTH];
      assign tap_vld  = (D == 0) ? adv : (int'(fill_count) >= D);

      assign out_valid[t]              = tap_vld;
      assign out_data[t*WIDTH +: WIDTH] = tap_vld ? tap_word : '0;
   end

endmodule

// File: tb/tb_ub_multitap_delay_line.sv
// Directed bench: default 4-tap stalling instance plus a free-running {0,3} instance.
module tb_ub_multitap_delay_line;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_en;
   logic [15:0] in_data;
   logic [63:0] out_data;
   logic [3:0]  out_valid;
   logic [6:0]  fill_count;

   logic        flush2, in_en2;
   logic [15:0] in_data2;
   logic [31:0] out_data2;
   logic [1:0]  out_valid2;
   logic [1:0]  fill_count2;

   int checks   = 0;
   int failures = 0;

   ub_multitap_delay_line dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_en      (in_en),
      .in_data    (in_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .fill_count (fill_count)
   );

   ub_multitap_delay_line #(
      .WIDTH      (16),
      .NTAPS      (2),
      .TAP_DELAYS ({16'd0, 16'd3}),
      .MAX_DELAY  (3),
      .STALL_EN   (1'b0)
   ) dut_free (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush2),
      .in_en      (in_en2),
      .in_data    (in_data2),
      .out_data   (out_data2),
      .out_valid  (out_valid2),
      .fill_count (fill_count2)
   );

   typedef struct {
      logic        en;
      logic [15:0] din;
      logic [6:0]  fill;
      logic [3:0]  vld;
      logic [15:0] t2;
      logic [15:0] t3;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] val(input int i);
      return 16'(i * 37 + 11);
   endfunction

   // Default taps are D = {66, 65, 1, 2} for taps 0..3; k accepted writes of val(0..k-1)
   function automatic logic [63:0] exp_taps(input int k);
      logic [63:0] e;
      e = '0;
      if (k >= 66) e[15:0]  = val(k - 66);
      if (k >= 65) e[31:16] = val(k - 65);
      if (k >= 1)  e[47:32] = val(k - 1);
      if (k >= 2)  e[63:48] = val(k - 2);
      return e;
   endfunction

   function automatic logic [3:0] exp_vld(input int k);
      logic [3:0] v;
      v[0] = (k >= 66);
      v[1] = (k >= 65);
      v[2] = (k >= 1);
      v[3] = (k >= 2);
      return v;
   endfunction

   task automatic pulse_reset();
      in_en = 1'b0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 16'd0,      7'd1,  4'b0100, 16'd0,  16'd0};
      tbl[1]  = '{1'b1, 16'd1,      7'd2,  4'b1100, 16'd1,  16'd0};
      tbl[2]  = '{1'b1, 16'd2,      7'd3,  4'b1100, 16'd2,  16'd1};
      tbl[3]  = '{1'b1, 16'd3,      7'd4,  4'b1100, 16'd3,  16'd2};
      tbl[4]  = '{1'b1, 16'd4,      7'd5,  4'b1100, 16'd4,  16'd3};
      tbl[5]  = '{1'b1, 16'd5,      7'd6,  4'b1100, 16'd5,  16'd4};
      tbl[6]  = '{1'b1, 16'd6,      7'd7,  4'b1100, 16'd6,  16'd5};
      tbl[7]  = '{1'b1, 16'd7,      7'd8,  4'b1100, 16'd7,  16'd6};
      tbl[8]  = '{1'b1, 16'd8,      7'd9,  4'b1100, 16'd8,  16'd7};
      tbl[9]  = '{1'b1, 16'd9,      7'd10, 4'b1100, 16'd9,  16'd8};
      tbl[10] = '{1'b0, 16'hDEAD,   7'd10, 4'b1100, 16'd9,  16'd8};
      tbl[11] = '{1'b0, 16'hDEAD,   7'd10, 4'b1100, 16'd9,  16'd8};
      tbl[12] = '{1'b0, 16'hDEAD,   7'd10, 4'b1100, 16'd9,  16'd8};
      tbl[13] = '{1'b0, 16'hDEAD,   7'd10, 4'b1100, 16'd9,  16'd8};
      tbl[14] = '{1'b0, 16'hDEAD,   7'd10, 4'b1100, 16'd9,  16'd8};
      tbl[15] = '{1'b1, 16'd10,     7'd11, 4'b1100, 16'd10, 16'd9};

      rst_n    = 1'b0;
      flush    = 1'b0;
      in_en    = 1'b0;
      in_data  = '0;
      flush2   = 1'b0;
      in_en2   = 1'b0;
      in_data2 = '0;

      #3;
      chk("reset_fill",  64'(fill_count), 64'd0);
      chk("reset_valid", 64'(out_valid),  64'd0);
      chk("reset_data",  out_data,        64'd0);

      // Fill from empty and keep streaming through several pointer wraps
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         in_en   = 1'b1;
         in_data = val(k - 1);
         tick();
         chk($sformatf("stream_fill_k%0d", k),  64'(fill_count), 64'((k < 66) ? k : 66));
         chk($sformatf("stream_valid_k%0d", k), 64'(out_valid),  64'(exp_vld(k)));
         chk($sformatf("stream_data_k%0d", k),  out_data,        exp_taps(k));
      end

      // Stall: table of writes 0..9, five idle cycles, then resume
      pulse_reset();
      for (int i = 0; i < 16; i++) begin
         in_en   = tbl[i].en;
         in_data = tbl[i].din;
         tick();
         chk($sformatf("stall_fill_r%0d", i),  64'(fill_count),     64'(tbl[i].fill));
         chk($sformatf("stall_valid_r%0d", i), 64'(out_valid),      64'(tbl[i].vld));
         chk($sformatf("stall_taps23_r%0d", i), 64'(out_data[63:32]), 64'({tbl[i].t3, tbl[i].t2}));
         chk($sformatf("stall_taps01_r%0d", i), 64'(out_data[31:0]),  64'd0);
      end

      // Flush coinciding with the write of 50: that word is discarded
      pulse_reset();
      for (int i = 0; i < 50; i++) begin
         in_en   = 1'b1;
         in_data = 16'(i);
         tick();
      end
      chk("preflush_fill", 64'(fill_count), 64'd50);
      chk("preflush_tap2", 64'(out_data[47:32]), 64'd49);
      in_data = 16'd50;
      flush   = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_fill",  64'(fill_count), 64'd0);
      chk("flush_valid", 64'(out_valid),  64'd0);
      chk("flush_data",  out_data,        64'd0);
      in_data = 16'd51;
      tick();
      chk("postflush1_fill",  64'(fill_count), 64'd1);
      chk("postflush1_valid", 64'(out_valid),  64'b0100);
      chk("postflush1_data",  out_data,        {16'd0, 16'd51, 32'd0});
      in_data = 16'd52;
      tick();
      chk("postflush2_valid", 64'(out_valid),  64'b1100);
      chk("postflush2_data",  out_data,        {16'd51, 16'd52, 32'd0});

      // Asynchronous reset between edges after 30 writes
      pulse_reset();
      for (int k = 1; k <= 30; k++) begin
         in_en   = 1'b1;
         in_data = val(k - 1);
         tick();
      end
      chk("prereset_fill", 64'(fill_count), 64'd30);
      chk("prereset_data", out_data, exp_taps(30));
      in_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_fill",  64'(fill_count), 64'd0);
      chk("async_reset_valid", 64'(out_valid),  64'd0);
      chk("async_reset_data",  out_data,        64'd0);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         in_en   = 1'b1;
         in_data = val(k - 1);
         tick();
         chk($sformatf("refill_fill_k%0d", k),  64'(fill_count), 64'(k));
         chk($sformatf("refill_valid_k%0d", k), 64'(out_valid),  64'(exp_vld(k)));
         chk($sformatf("refill_data_k%0d", k),  out_data,        exp_taps(k));
      end
      in_en = 1'b0;

      // Free-running instance: advances every cycle although in_en stays low
      flush2   = 1'b1;
      in_data2 = 16'hFFFF;
      tick();
      flush2 = 1'b0;
      chk("free_flush_fill",  64'(fill_count2),   64'd0);
      chk("free_flush_tap1v", 64'(out_valid2[1]), 64'd0);
      for (int k = 1; k <= 8; k++) begin
         in_data2 = val(100 + k - 1);
         #1;
         chk($sformatf("free_bypass_data_k%0d", k),  64'(out_data2[15:0]), 64'(val(100 + k - 1)));
         chk($sformatf("free_bypass_valid_k%0d", k), 64'(out_valid2[0]),   64'd1);
         tick();
         chk($sformatf("free_fill_k%0d", k),   64'(fill_count2),   64'((k < 3) ? k : 3));
         chk($sformatf("free_tap1v_k%0d", k),  64'(out_valid2[1]), 64'((k >= 3) ? 1 : 0));
         chk($sformatf("free_tap1d_k%0d", k),  64'(out_data2[31:16]),
             (k >= 3) ? 64'(val(100 + k - 3)) : 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
